conv_layer_ctrl: RTL and testbench
==================================

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameter I_SIZE, default 5, input feature-map edge length.
REQ-002 Parameter K_SIZE, default 3, kernel edge length; O_SIZE = I_SIZE-K_SIZE+1 derived, not a parameter.
REQ-003 Parameter ADDR_WIDTH, default 16, buffer address width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle layer start request.
REQ-007 abort  input  1  synchronous abort of a running layer.
REQ-008 cfg_channels  input  8  channel passes per layer; 0 is illegal.
REQ-009 cfg_timeout  input  16  max cycles per pass awaiting conv_done; 0 disables watchdog.
REQ-010 conv_en  output  1  one-cycle pulse starting one convolution pass.
REQ-011 conv_done  input  1  one-cycle pulse from the engine ending a pass.
REQ-012 ch_idx  output  8  current channel index.
REQ-013 in_base / w_base / r_base  output  ADDR_WIDTH each  input, weight, result buffer base addresses for current channel.
REQ-014 busy  output  1  high from the cycle after accepted start until the cycle done pulses.
REQ-015 done  output  1  one-cycle layer-complete pulse (normal, error or abort).
REQ-016 err  output  1  sticky error flag; cleared by next accepted start.

Function
REQ-017 States IDLE, ISSUE, WAIT, FIN; encoding internal.
REQ-018 IDLE: start with cfg_channels!=0 latches cfg_channels/cfg_timeout, clears err, sets ch_idx=0 and bases=0, goes ISSUE.
REQ-019 IDLE: start with cfg_channels==0 sets err=1, goes FIN; conv_en never asserted.
REQ-020 ISSUE: conv_en=1 for exactly one cycle, watchdog loaded with latched timeout, goes WAIT.
REQ-021 WAIT: conv_done on last channel (ch_idx==cfg_channels-1) goes FIN; otherwise ch_idx+1, bases advance, goes ISSUE.
REQ-022 Base advance per channel: in_base += I_SIZE*I_SIZE, w_base += K_SIZE*K_SIZE, r_base += O_SIZE*O_SIZE, wrapping modulo 2^ADDR_WIDTH.
REQ-023 ch_idx and bases registered; stable from ISSUE cycle until conv_done of that pass.
REQ-024 WAIT: watchdog decrements each cycle; reaching 0 with latched timeout!=0 sets err=1, goes FIN.
REQ-025 conv_done and watchdog expiry in same cycle: conv_done wins, no error.
REQ-026 abort in ISSUE or WAIT sets err=1, goes FIN; abort in IDLE/FIN ignored; abort beats conv_done and watchdog.
REQ-027 FIN: done=1 one cycle, busy=0, goes IDLE.
REQ-028 start outside IDLE ignored; configuration inputs sampled only on accepted start.
REQ-029 conv_done outside WAIT ignored.
REQ-030 Latency: start at cycle T -> conv_en at T+1; conv_done at N -> next conv_en at N+1 or done at N+1.

Reset
REQ-031 rstn low: state IDLE, conv_en=0, done=0, busy=0, err=0, ch_idx=0, all bases 0, watchdog 0, latched config 0.
REQ-032 Reset mid-layer abandons the layer with no done pulse; first edge after release is in IDLE.

Structure
REQ-033 State encoding and derived per-channel stride constants in shared package conv_pkg.
REQ-034 Watchdog counter as sub-module conv_watchdog (load, enable, expired); rest flat.

Verification
REQ-035 Defaults, cfg_channels=3, engine conv_done 10 cycles after each conv_en -> three conv_en pulses; bases (0,0,0),(25,9,9),(50,18,18); one done; err=0.
REQ-036 cfg_channels=0, start -> no conv_en; done the cycle after start's acceptance; err=1; busy stays 0.
REQ-037 cfg_channels=2, cfg_timeout=5, engine silent -> err=1, done 6 cycles after conv_en, only one conv_en.
REQ-038 conv_done coincident with watchdog expiry on last channel -> err=0, done next cycle.
REQ-039 start pulsed again during WAIT, then abort -> second start ignored; err=1, done next cycle, back to IDLE.
REQ-040 rstn asserted in WAIT of channel 1, released, new start cfg_channels=1 -> ch_idx=0, bases 0, single conv_en, clean done.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer controller: FSM state encoding
// and per-channel buffer stride helpers.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FIN   = 2'd3
   } conv_state_e;

   function automatic int unsigned in_stride(input int unsigned i_size);
      return i_size * i_size;
   endfunction

   function automatic int unsigned w_stride(input int unsigned k_size);
      return k_size * k_size;
   endfunction

   function automatic int unsigned r_stride(input int unsigned i_size, input int unsigned k_size);
      return (i_size - k_size + 1) * (i_size - k_size + 1);
   endfunction

   localparam int unsigned DEF_IN_STRIDE = in_stride(5);
   localparam int unsigned DEF_W_STRIDE  = w_stride(3);
   localparam int unsigned DEF_R_STRIDE  = r_stride(5, 3);

endpackage

// File: rtl/conv_watchdog.sv
// Per-pass watchdog: down-counter loaded at pass issue, flags the terminal count.
module conv_watchdog #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   output logic             expired
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flag on the step to zero so the controller leaves WAIT on that same edge.
   assign expired = enable && !load && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer: issues one engine pass per channel, advancing
// the input/weight/result buffer bases, with abort and per-pass watchdog.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | conv_en pulse, watchdog loaded
// WAIT  | waiting for conv_done, watchdog running
// FIN   | done pulse, back to IDLE
module conv_layer_ctrl
   import conv_pkg::*;
#(
   parameter int I_SIZE     = 5,
   parameter int K_SIZE     = 3,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [7:0]            cfg_channels,
   input  logic [15:0]           cfg_timeout,
   output logic                  conv_en,
   input  logic                  conv_done,
   output logic [7:0]            ch_idx,
   output logic [ADDR_WIDTH-1:0] in_base,
   output logic [ADDR_WIDTH-1:0] w_base,
   output logic [ADDR_WIDTH-1:0] r_base,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [ADDR_WIDTH-1:0] IN_STRIDE = ADDR_WIDTH'(in_stride(I_SIZE));
   localparam logic [ADDR_WIDTH-1:0] W_STRIDE  = ADDR_WIDTH'(w_stride(K_SIZE));
   localparam logic [ADDR_WIDTH-1:0] R_STRIDE  = ADDR_WIDTH'(r_stride(I_SIZE, K_SIZE));

   conv_state_e           state_q, state_d;
   logic [7:0]            ch_q, ch_d;
   logic [7:0]            nch_q, nch_d;
   logic [15:0]           tmo_q, tmo_d;
   logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
   logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
   logic [ADDR_WIDTH-1:0] r_base_q, r_base_d;
   logic                  err_q, err_d;
   logic                  wd_load, wd_expired;

   conv_watchdog #(.WIDTH(16)) u_watchdog (
      .clk      (clk),
      .rstn     (rstn),
      .load     (wd_load),
      .load_val (tmo_q),
      .enable   (state_q == ST_WAIT),
      .expired  (wd_expired)
   );

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      nch_d     = nch_q;
      tmo_d     = tmo_q;
      in_base_d = in_base_q;
      w_base_d  = w_base_q;
      r_base_d  = r_base_q;
      err_d     = err_q;
      wd_load   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_channels == 8'd0) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  nch_d     = cfg_channels;
                  tmo_d     = cfg_timeout;
                  err_d     = 1'b0;
                  ch_d      = 8'd0;
                  in_base_d = '0;
                  w_base_d  = '0;
                  r_base_d  = '0;
                  state_d   = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            wd_load = 1'b1;
            if (abort) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Priority: abort, then conv_done, then watchdog expiry.
            if (abort) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else if (conv_done) begin
               if (ch_q == nch_q - 8'd1) begin
                  state_d = ST_FIN;
               end else begin
                  ch_d      = ch_q + 8'd1;
                  in_base_d = in_base_q + IN_STRIDE;
                  w_base_d  = w_base_q + W_STRIDE;
                  r_base_d  = r_base_q + R_STRIDE;
                  state_d   = ST_ISSUE;
               end
            end else if (wd_expired && (tmo_q != 16'd0)) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         ch_q      <= 8'd0;
         nch_q     <= 8'd0;
         tmo_q     <= 16'd0;
         in_base_q <= '0;
         w_base_q  <= '0;
         r_base_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         nch_q     <= nch_d;
         tmo_q     <= tmo_d;
         in_base_q <= in_base_d;
         w_base_q  <= w_base_d;
         r_base_q  <= r_base_d;
         err_q     <= err_d;
      end
   end

   assign conv_en = (state_q == ST_ISSUE);
   assign done    = (state_q == ST_FIN);
   assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign ch_idx  = ch_q;
   assign in_base = in_base_q;
   assign w_base  = w_base_q;
   assign r_base  = r_base_q;
   assign err     = err_q;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench for conv_layer_ctrl: stimulus pushes expected passes and
// layer completions, a monitor pops and compares whenever the DUT presents them.
module tb_conv_layer_ctrl;

   localparam int I_SIZE     = 5;
   localparam int K_SIZE     = 3;
   localparam int ADDR_WIDTH = 16;
   localparam int O_SIZE     = I_SIZE - K_SIZE + 1;
   localparam int AMOD       = 1 << ADDR_WIDTH;

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic                  conv_done = 1'b0;
   logic [7:0]            cfg_channels = 8'd0;
   logic [15:0]           cfg_timeout = 16'd0;
   logic                  conv_en, busy, done, err;
   logic [7:0]            ch_idx;
   logic [ADDR_WIDTH-1:0] in_base, w_base, r_base;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int eng_delay = 0;

   typedef struct {int cyc; int ch; int ib; int wb; int rb;} pass_t;
   typedef struct {int cyc; int err;} fin_t;
   pass_t exp_pass[$];
   fin_t  exp_fin[$];

   conv_layer_ctrl #(
      .I_SIZE(I_SIZE), .K_SIZE(K_SIZE), .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .abort        (abort),
      .cfg_channels (cfg_channels),
      .cfg_timeout  (cfg_timeout),
      .conv_en      (conv_en),
      .conv_done    (conv_done),
      .ch_idx       (ch_idx),
      .in_base      (in_base),
      .w_base       (w_base),
      .r_base       (r_base),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic pass_t mk_pass(input int c, input int i);
      pass_t p;
      p.cyc = c;
      p.ch  = i;
      p.ib  = (i * I_SIZE * I_SIZE) % AMOD;
      p.wb  = (i * K_SIZE * K_SIZE) % AMOD;
      p.rb  = (i * O_SIZE * O_SIZE) % AMOD;
      return p;
   endfunction

   // Engine model: answers each conv_en with conv_done eng_delay cycles later (0 = silent).
   initial begin
      forever begin
         @(negedge clk);
         if (rstn && conv_en && eng_delay != 0) begin
            repeat (eng_delay) @(posedge clk);
            #1 conv_done = 1'b1;
            @(posedge clk);
            #1 conv_done = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      pass_t p, cur;
      fin_t  f;
      bit    open;
      open = 1'b0;
      cur = mk_pass(0, 0);
      forever begin
         @(negedge clk);
         if (!rstn) begin
            open = 1'b0;
         end else begin
            if (conv_en) begin
               if (exp_pass.size() == 0) begin
                  check("unexpected conv_en", 1, 0);
               end else begin
                  p = exp_pass.pop_front();
                  check("conv_en cycle", cyc, p.cyc);
                  check("ch_idx", ch_idx, p.ch);
                  check("in_base", in_base, p.ib);
                  check("w_base", w_base, p.wb);
                  check("r_base", r_base, p.rb);
                  check("busy in pass", busy, 1);
                  cur = p;
                  open = 1'b1;
               end
            end
            if (conv_done && open && !conv_en) begin
               check("ch_idx stable", ch_idx, cur.ch);
               check("in_base stable", in_base, cur.ib);
               check("r_base stable", r_base, cur.rb);
               open = 1'b0;
            end
            if (done) begin
               open = 1'b0;
               if (exp_fin.size() == 0) begin
                  check("unexpected done", 1, 0);
               end else begin
                  f = exp_fin.pop_front();
                  check("done cycle", cyc, f.cyc);
                  check("err at done", err, f.err);
                  check("busy at done", busy, 0);
               end
            end
         end
      end
   end

   task automatic wait_idle(input bit exp_err, input int drain);
      int n;
      n = 0;
      while ((exp_pass.size() != 0 || exp_fin.size() != 0) && n < 500) begin
         next_cycle();
         n++;
      end
      check("layer completes in time", (n < 500), 1);
      if (n >= 500) begin
         exp_pass.delete();
         exp_fin.delete();
      end
      repeat (drain + 2) next_cycle();
      check("err after layer", err, exp_err);
      check("busy when idle", busy, 0);
   endtask

   // Reference: passes start one cycle after start, each lasting delay cycles in
   // WAIT; a pass whose engine is slower than the timeout ends the layer with err.
   task automatic run_layer(input int ch, input int to, input int delay);
      int  t, c;
      bit  e;
      next_cycle();
      eng_delay    = delay;
      cfg_channels = 8'(ch);
      cfg_timeout  = 16'(to);
      start        = 1'b1;
      t = cyc;
      e = 1'b0;
      if (ch == 0) begin
         exp_fin.push_back(fin_t'{t + 1, 1});
         e = 1'b1;
      end else begin
         c = t + 1;
         for (int i = 0; i < ch; i++) begin
            exp_pass.push_back(mk_pass(c, i));
            if (delay == 0 || (to != 0 && delay > to)) begin
               exp_fin.push_back(fin_t'{c + to + 1, 1});
               e = 1'b1;
               break;
            end
            c = c + delay + 1;
            if (i == ch - 1) exp_fin.push_back(fin_t'{c, 0});
         end
      end
      next_cycle();
      start        = 1'b0;
      cfg_channels = 8'($urandom);
      cfg_timeout  = 16'($urandom);
      wait_idle(e, delay);
   endtask

   initial begin
      int t, a, ch, to, dl;
      repeat (2) next_cycle();
      check("reset conv_en", conv_en, 0);
      check("reset done", done, 0);
      check("reset busy", busy, 0);
      check("reset err", err, 0);
      check("reset ch_idx", ch_idx, 0);
      check("reset bases", {in_base, w_base, r_base}, 0);
      rstn = 1'b1;
      repeat (2) next_cycle();

      run_layer(3, 0, 10);
      run_layer(0, 9, 3);
      run_layer(2, 5, 0);
      run_layer(2, 7, 7);
      run_layer(1, 3, 3);
      run_layer(3, 4, 2);

      // Second start during WAIT is ignored, abort ends the layer with err.
      next_cycle();
      eng_delay = 20; cfg_channels = 8'd3; cfg_timeout = 16'd0; start = 1'b1;
      t = cyc;
      exp_pass.push_back(mk_pass(t + 1, 0));
      next_cycle(); start = 1'b0;
      repeat (3) next_cycle();
      start = 1'b1;
      next_cycle(); start = 1'b0;
      next_cycle(); abort = 1'b1; a = cyc;
      exp_fin.push_back(fin_t'{a + 1, 1});
      next_cycle(); abort = 1'b0;
      wait_idle(1, 20);
      abort = 1'b1;
      next_cycle(); abort = 1'b0;
      repeat (3) next_cycle();
      check("abort in idle keeps err", err, 1);

      // Reset during WAIT of channel 1 abandons the layer silently.
      next_cycle();
      eng_delay = 10; cfg_channels = 8'd3; cfg_timeout = 16'd0; start = 1'b1;
      t = cyc;
      exp_pass.push_back(mk_pass(t + 1, 0));
      exp_pass.push_back(mk_pass(t + 12, 1));
      next_cycle(); start = 1'b0;
      repeat (14) next_cycle();
      rstn = 1'b0;
      next_cycle();
      check("mid reset conv_en", conv_en, 0);
      check("mid reset done", done, 0);
      check("mid reset busy", busy, 0);
      check("mid reset err", err, 0);
      check("mid reset ch_idx", ch_idx, 0);
      check("mid reset bases", {in_base, w_base, r_base}, 0);
      rstn = 1'b1;
      check("passes seen before reset", exp_pass.size(), 0);
      exp_pass.delete();
      repeat (12) next_cycle();
      run_layer(1, 0, 4);

      for (int k = 0; k < 10; k++) begin
         ch = $urandom_range(0, 4);
         to = $urandom_range(0, 9);
         dl = $urandom_range(1, 9);
         if (to != 0 && $urandom_range(0, 3) == 0) dl = 0;
         run_layer(ch, to, dl);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got cycle %0d, want completion", cyc);
      $fatal(1, "bench timeout");
   end

endmodule
